// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state codes and requester ids.
// Also provides the id-to-done-vector helper used by the top.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;
    typedef logic [1:0] arb_id_t;

    localparam arb_state_t S_IDLE  = 2'd0;
    localparam arb_state_t S_ISSUE = 2'd1;
    localparam arb_state_t S_WAIT  = 2'd2;
    localparam arb_state_t S_RESP  = 2'd3;

    localparam arb_id_t ID_NONE = 2'd0;
    localparam arb_id_t ID_LD   = 2'd1;
    localparam arb_id_t ID_FE   = 2'd2;
    localparam arb_id_t ID_DT   = 2'd3;

    // Bit 0 = loader, bit 1 = fetch, bit 2 = data.
    function automatic logic [2:0] id_onehot(input arb_id_t id);
        logic [2:0] v;
        case (id)
            ID_LD:   v = 3'b001;
            ID_FE:   v = 3'b010;
            ID_DT:   v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side strobes around mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              ld_req, fe_req, dt_req;
    logic              ld_we, fe_we, dt_we;
    logic [ADDR_W-1:0] ld_addr, fe_addr, dt_addr;
    logic [DATA_W-1:0] ld_wdata, fe_wdata, dt_wdata;
    logic              ld_done, fe_done, dt_done;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_req, fe_req, dt_req, ld_we, fe_we, dt_we,
        input  ld_addr, fe_addr, dt_addr, ld_wdata, fe_wdata, dt_wdata,
        input  mem_rdata,
        output ld_done, fe_done, dt_done, rdata, grant_id, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, fe_req, dt_req, ld_we, fe_we, dt_we,
        output ld_addr, fe_addr, dt_addr, ld_wdata, fe_wdata, dt_wdata,
        output mem_rdata,
        input  ld_done, fe_done, dt_done, rdata, grant_id, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_pick.sv
// Winner selection: loader has absolute priority, fetch/data alternate
// based on which of them was granted last.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic    ld_req,
    input  logic    fe_req,
    input  logic    dt_req,
    input  arb_id_t rr_last,
    output arb_id_t winner
);

    // Combinational priority / round-robin decision.
    always_comb begin
        winner = ID_NONE;
        if (ld_req) begin
            winner = ID_LD;
        end else if (fe_req && dt_req) begin
            winner = (rr_last == ID_FE) ? ID_DT : ID_FE;
        end else if (fe_req) begin
            winner = ID_FE;
        end else if (dt_req) begin
            winner = ID_DT;
        end else begin
            winner = ID_NONE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter for the shared 4096x32 unified memory.
// Sequences IDLE -> ISSUE -> (WAIT) -> RESP against a fixed-latency array.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_t        state_q, state_d;
    arb_id_t           owner_q, owner_d;
    arb_id_t           rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        done_q, done_d;
    logic              busy_q, busy_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;

    arb_id_t           winner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    arb_pick u_pick (
        .ld_req  (bus.ld_req),
        .fe_req  (bus.fe_req),
        .dt_req  (bus.dt_req),
        .rr_last (rr_last_q),
        .winner  (winner_s)
    );

    // Route the winning requester's command fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (winner_s)
            ID_LD: begin
                sel_we_s = bus.ld_we; sel_addr_s = bus.ld_addr; sel_wdata_s = bus.ld_wdata;
            end
            ID_FE: begin
                sel_we_s = bus.fe_we; sel_addr_s = bus.fe_addr; sel_wdata_s = bus.fe_wdata;
            end
            ID_DT: begin
                sel_we_s = bus.dt_we; sel_addr_s = bus.dt_addr; sel_wdata_s = bus.dt_wdata;
            end
            default: begin
                sel_we_s = 1'b0; sel_addr_s = {ADDR_W{1'b0}}; sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Next-state logic; strobes and done are computed one cycle ahead so every output is a flop.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 3'b000;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (winner_s != ID_NONE) begin
                    state_d  = S_ISSUE;
                    owner_d  = winner_s;
                    we_d     = sel_we_s;
                    addr_d   = sel_addr_s;
                    wdata_d  = sel_wdata_s;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    mem_we_d = sel_we_s;
                    // Loader grants must not disturb the fetch/data rotation.
                    rr_last_d = (winner_s == ID_LD) ? rr_last_q : winner_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                    done_d  = id_onehot(owner_q);
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RESP;
                    rdata_d = bus.mem_rdata;
                    done_d  = id_onehot(owner_q);
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                owner_d = ID_NONE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = ID_NONE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            owner_q   <= ID_NONE;
            rr_last_q <= ID_DT;
            we_q      <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            done_q    <= 3'b000;
            busy_q    <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
        end
    end

    assign bus.ld_done   = done_q[0];
    assign bus.fe_done   = done_q[1];
    assign bus.dt_done   = done_q[2];
    assign bus.rdata     = rdata_q;
    assign bus.grant_id  = owner_q;
    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-level model of grants, latencies and memory contents.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 12;
    localparam int MEM_LAT = 2;

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory array with a two-stage read pipeline; garbage unless read was strobed.
    logic [31:0] mem [4096];
    logic [31:0] s1, s2;
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        s1 <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
        s2 <= s1;
    end
    assign bus.mem_rdata = s2;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_mem [4096];
    int          m_owner, m_t, m_total, rr_last;
    bit          m_we;
    logic [11:0] m_addr, last_addr;
    logic [31:0] m_wdata, last_wdata, exp_rdata;

    // Requester agents (index 1 loader, 2 fetch, 3 data)
    bit          a_req   [1:3];
    bit          a_we    [1:3];
    logic [11:0] a_addr  [1:3];
    logic [31:0] a_wdata [1:3];
    txn_t        q_ld[$], q_fe[$], q_dt[$];
    bit          random_mode = 1'b0;
    int          n_done  [1:3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t rand_txn(input int id);
        txn_t t;
        t.we    = (id == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        t.addr  = 12'($urandom_range(0, 31));
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic pop_txn(input int id, output bit ok, output txn_t t);
        ok = 1'b0;
        t  = '{1'b0, 12'd0, 32'd0};
        if (id == 1 && q_ld.size() > 0) begin t = q_ld.pop_front(); ok = 1'b1; end
        if (id == 2 && q_fe.size() > 0) begin t = q_fe.pop_front(); ok = 1'b1; end
        if (id == 3 && q_dt.size() > 0) begin t = q_dt.pop_front(); ok = 1'b1; end
    endtask

    task automatic drive_bus();
        bus.ld_req = a_req[1]; bus.ld_we = a_we[1]; bus.ld_addr = a_addr[1]; bus.ld_wdata = a_wdata[1];
        bus.fe_req = a_req[2]; bus.fe_we = a_we[2]; bus.fe_addr = a_addr[2]; bus.fe_wdata = a_wdata[2];
        bus.dt_req = a_req[3]; bus.dt_we = a_we[3]; bus.dt_addr = a_addr[3]; bus.dt_wdata = a_wdata[3];
    endtask

    task automatic model_reset();
        m_owner = 0; m_t = 0; m_total = 0; rr_last = 3;
        exp_rdata = 32'd0; last_addr = 12'd0; last_wdata = 32'd0;
    endtask

    // One clock: check outputs at negedge, let agents react, then advance the model past the next edge.
    task automatic do_cycle();
        logic [3:1] ed;
        logic [1:0] eg;
        logic       eb, een, ewe;
        txn_t       t;
        bit         ok;
        int         win;
        @(negedge clock);
        ed = 3'b000; eg = 2'd0; eb = 1'b0; een = 1'b0; ewe = 1'b0;
        if (m_owner != 0) begin
            eb = 1'b1;
            eg = 2'(m_owner);
            if (m_t == 1) begin
                een = 1'b1; ewe = m_we; last_addr = m_addr; last_wdata = m_wdata;
            end
            if (m_t == m_total) begin
                ed[m_owner] = 1'b1;
                if (!m_we) exp_rdata = m_mem[m_addr];
            end
        end
        check_val("busy",      32'(bus.busy),     32'(eb));
        check_val("grant_id",  32'(bus.grant_id), 32'(eg));
        check_val("mem_en",    32'(bus.mem_en),   32'(een));
        check_val("mem_we",    32'(bus.mem_we),   32'(ewe));
        check_val("mem_addr",  32'(bus.mem_addr), 32'(last_addr));
        check_val("mem_wdata", bus.mem_wdata,     last_wdata);
        check_val("ld_done",   32'(bus.ld_done),  32'(ed[1]));
        check_val("fe_done",   32'(bus.fe_done),  32'(ed[2]));
        check_val("dt_done",   32'(bus.dt_done),  32'(ed[3]));
        check_val("rdata",     bus.rdata,         exp_rdata);
        if (bus.ld_done) n_done[1]++;
        if (bus.fe_done) n_done[2]++;
        if (bus.dt_done) n_done[3]++;

        for (int id = 1; id <= 3; id++) begin
            if (ed[id] || !a_req[id]) begin
                pop_txn(id, ok, t);
                if (!ok && random_mode && ed[id] && $urandom_range(0, 1) == 1) begin
                    t = rand_txn(id); ok = 1'b1;
                end
                if (!ok && random_mode && !ed[id] && $urandom_range(0, (id == 1) ? 15 : 3) == 0) begin
                    t = rand_txn(id); ok = 1'b1;
                end
                if (ok) begin
                    a_req[id] = 1'b1; a_we[id] = t.we; a_addr[id] = t.addr; a_wdata[id] = t.wdata;
                end else begin
                    a_req[id] = 1'b0;
                end
            end
        end
        drive_bus();

        if (reset_n) begin
            if (m_owner == 0) begin
                win = 0;
                if (a_req[1]) win = 1;
                else if (a_req[2] && a_req[3]) win = (rr_last == 2) ? 3 : 2;
                else if (a_req[2]) win = 2;
                else if (a_req[3]) win = 3;
                if (win != 0) begin
                    m_owner = win; m_t = 1;
                    m_we = a_we[win]; m_addr = a_addr[win]; m_wdata = a_wdata[win];
                    m_total = m_we ? 2 : MEM_LAT + 2;
                    if (win != 1) rr_last = win;
                    if (m_we) m_mem[m_addr] = m_wdata;
                end
            end else if (m_t == m_total) begin
                m_owner = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    // Called at a negedge: drop reset, check everything cleared, hold, release.
    task automatic apply_reset(input int hold);
        reset_n = 1'b0;
        q_ld.delete(); q_fe.delete(); q_dt.delete();
        for (int id = 1; id <= 3; id++) begin
            a_req[id] = 1'b0; a_we[id] = 1'b0; a_addr[id] = 12'd0; a_wdata[id] = 32'd0;
        end
        drive_bus();
        #1;
        check_val("rst_busy",  32'(bus.busy),     32'd0);
        check_val("rst_grant", 32'(bus.grant_id), 32'd0);
        check_val("rst_en",    32'(bus.mem_en),   32'd0);
        check_val("rst_addr",  32'(bus.mem_addr), 32'd0);
        check_val("rst_rdata", bus.rdata,         32'd0);
        check_val("rst_done",  32'({bus.ld_done, bus.fe_done, bus.dt_done}), 32'd0);
        model_reset();
        repeat (hold) do_cycle();
        reset_n = 1'b1;
        for (int id = 1; id <= 3; id++) n_done[id] = 0;
    endtask

    initial begin
        model_reset();
        for (int id = 1; id <= 3; id++) begin
            a_req[id] = 1'b0; a_we[id] = 1'b0; a_addr[id] = 12'd0; a_wdata[id] = 32'd0; n_done[id] = 0;
        end
        drive_bus();
        for (int i = 0; i <= 32; i++) begin
            @(negedge clock);
            pl_en   = 1'b1;
            pl_addr = (i == 32) ? 12'hFEA : 12'(i);
            pl_data = (i == 32) ? 32'h0000_00AB : $urandom;
            m_mem[pl_addr] = pl_data;
        end
        @(negedge clock);
        pl_en = 1'b0;
        apply_reset(2);

        // Reset lands in WAIT of a fetch read; no fe_done may follow.
        q_fe.push_back('{1'b0, 12'd5, 32'd0});
        repeat (3) do_cycle();
        apply_reset(3);
        repeat (6) do_cycle();
        check_val("t1_no_fe_done", 32'(n_done[2]), 32'd0);

        q_fe.push_back('{1'b0, 12'hFEA, 32'd0});
        repeat (8) do_cycle();
        check_val("t2_rdata_ab", bus.rdata, 32'h0000_00AB);

        q_dt.push_back('{1'b1, 12'd2, 32'd29});
        repeat (5) do_cycle();
        check_val("t3_mem2", mem[2], 32'd29);
        check_val("t3_rdata_kept", bus.rdata, 32'h0000_00AB);

        apply_reset(1);
        for (int i = 0; i < 4; i++) begin
            q_fe.push_back('{1'b0, 12'(i + 1), 32'd0});
            q_dt.push_back('{1'b0, 12'(i + 8), 32'd0});
        end
        repeat (48) do_cycle();
        check_val("t4_fe_cnt", 32'(n_done[2]), 32'd4);
        check_val("t4_dt_cnt", 32'(n_done[3]), 32'd4);

        apply_reset(1);
        q_ld.push_back('{1'b0, 12'd3, 32'd0});
        q_fe.push_back('{1'b0, 12'd4, 32'd0});
        q_dt.push_back('{1'b0, 12'd6, 32'd0});
        repeat (20) do_cycle();
        check_val("t5_ld_cnt", 32'(n_done[1]), 32'd1);
        check_val("t5_fe_cnt", 32'(n_done[2]), 32'd1);
        check_val("t5_dt_cnt", 32'(n_done[3]), 32'd1);

        apply_reset(1);
        q_ld.push_back('{1'b1, 12'd0, 32'd10});
        q_ld.push_back('{1'b1, 12'd1, 32'd29});
        q_ld.push_back('{1'b1, 12'd2, 32'd0});
        repeat (14) do_cycle();
        check_val("t6_mem0", mem[0], 32'd10);
        check_val("t6_mem1", mem[1], 32'd29);
        check_val("t6_mem2", mem[2], 32'd0);
        check_val("t6_ld_cnt", 32'(n_done[1]), 32'd3);

        random_mode = 1'b1;
        repeat (3000) do_cycle();
        random_mode = 1'b0;
        repeat (60) do_cycle();
        for (int i = 0; i < 32; i++) check_val("final_mem", mem[i], m_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
